// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that owns the link to the APB_UART slave.
// Runs the three-write config sequence, drains a TX byte queue, serves RX polls.
module uart_apb_sequencer #(
    parameter int          TX_DEPTH = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [11:0] A_BAUD   = 12'h410,
    parameter logic [11:0] A_CTRL   = 12'h408,
    parameter logic [11:0] A_STATE  = 12'h404,
    parameter logic [11:0] A_DATA   = 12'h400
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cfg_start,
    input  logic [7:0]  cfg_baud,
    input  logic [7:0]  cfg_ctrl,
    input  logic [7:0]  cfg_state,
    output logic        cfg_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        rx_poll,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [11:0] PADDR,
    output logic [7:0]  PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef enum logic [1:0] {K_CFG, K_TX, K_RX} kind_t;

    state_t state, state_n;
    kind_t  kind, kind_n;

    logic [7:0]  fifo [TX_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push;

    logic        cfg_pend, rx_pend, rr_tx;
    logic [1:0]  cfg_step;
    logic [23:0] cfg_pv, cfg_av;
    logic [9:0]  cnt;

    logic        g_cfg, g_new, g_tx, g_rx, xfer_ok, xfer_to;
    logic        psel_n, penable_n, pwrite_n;
    logic [11:0] paddr_n;
    logic [7:0]  pwdata_n;
    logic        unused_prdata;

    assign unused_prdata = ^PRDATA[31:8];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready = ~PRESET & ~full;
    assign push     = tx_valid & tx_ready;
    assign busy     = (state != IDLE) | cfg_pend | rx_pend |
                      (cfg_step != 2'd0) | ~empty;

    always_comb begin
        state_n   = state;
        kind_n    = kind;
        psel_n    = PSEL;
        penable_n = PENABLE;
        pwrite_n  = PWRITE;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
        g_cfg     = 1'b0;
        g_new     = 1'b0;
        g_tx      = 1'b0;
        g_rx      = 1'b0;
        xfer_ok   = 1'b0;
        xfer_to   = 1'b0;
        unique case (state)
            IDLE: begin
                // an unfinished config sequence is never interleaved
                if (cfg_step != 2'd0 || cfg_pend) begin
                    g_cfg = 1'b1;
                    g_new = (cfg_step == 2'd0);
                end else if (cfg_done && !empty && (rr_tx || !rx_pend)) begin
                    g_tx = 1'b1;
                end else if (cfg_done && rx_pend) begin
                    g_rx = 1'b1;
                end
                if (g_cfg || g_tx || g_rx) begin
                    state_n   = SETUP;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    pwrite_n  = 1'b1;
                    paddr_n   = A_DATA;
                    pwdata_n  = 8'h00;
                end
                if (g_cfg) begin
                    kind_n = K_CFG;
                    case (cfg_step)
                        2'd0: begin
                            paddr_n  = A_BAUD;
                            pwdata_n = cfg_pv[23:16];
                        end
                        2'd1: begin
                            paddr_n  = A_CTRL;
                            pwdata_n = cfg_av[15:8];
                        end
                        default: begin
                            paddr_n  = A_STATE;
                            pwdata_n = cfg_av[7:0];
                        end
                    endcase
                end
                if (g_tx) begin
                    kind_n   = K_TX;
                    pwdata_n = fifo[rd_ptr[AW-1:0]];
                end
                if (g_rx) begin
                    kind_n   = K_RX;
                    pwrite_n = 1'b0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: begin
                xfer_ok = PREADY;
                xfer_to = !PREADY && (cnt == 10'(TIMEOUT - 1));
                if (xfer_ok || xfer_to) begin
                    state_n   = IDLE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                end
            end
            default: begin
                state_n   = IDLE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            kind    <= K_CFG;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            PSEL    <= psel_n;
            PENABLE <= penable_n;
            PWRITE  <= pwrite_n;
            PADDR   <= paddr_n;
            PWDATA  <= pwdata_n;
            cnt     <= (state == ACCESS) ? cnt + 10'd1 : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cfg_pend <= 1'b0;
            cfg_step <= 2'd0;
            cfg_pv   <= '0;
            cfg_av   <= '0;
            cfg_done <= 1'b0;
            rx_pend  <= 1'b0;
            rr_tx    <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            err      <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr[AW-1:0]] <= tx_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (g_tx) rd_ptr <= rd_ptr + 1'b1;
            if (g_tx) rr_tx <= 1'b0;
            if (g_rx) rr_tx <= 1'b1;
            // a pulse on the grant cycle is a fresh request
            cfg_pend <= cfg_start | (cfg_pend & ~g_new);
            rx_pend  <= rx_poll | (rx_pend & ~g_rx);
            if (cfg_start) cfg_pv <= {cfg_baud, cfg_ctrl, cfg_state};
            if (g_new) begin
                cfg_av   <= cfg_pv;
                cfg_done <= 1'b0;
            end
            if (xfer_ok && kind == K_CFG) begin
                if (cfg_step == 2'd2) begin
                    cfg_step <= 2'd0;
                    cfg_done <= 1'b1;
                end else begin
                    cfg_step <= cfg_step + 2'd1;
                end
            end
            if (xfer_to && kind == K_CFG) cfg_step <= 2'd0;
            rx_valid <= xfer_ok && (kind == K_RX);
            if (xfer_ok && kind == K_RX) rx_data <= PRDATA[7:0];
            err <= xfer_to | (err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: vector table plus APB scoreboard for the sequencer.
// An APB responder with programmable wait states and a hang mode.
module tb_uart_apb_sequencer;

    localparam int TO    = 16;
    localparam int DEPTH = 8;
    localparam logic [20:0] RD = {1'b0, 12'h400, 8'h00};

    logic        PCLK;
    logic        PRESET;
    logic        cfg_start;
    logic [7:0]  cfg_baud, cfg_ctrl, cfg_state;
    logic        cfg_done;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_poll;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    uart_apb_sequencer #(.TX_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cfg_start(cfg_start), .cfg_baud(cfg_baud),
        .cfg_ctrl(cfg_ctrl), .cfg_state(cfg_state),
        .cfg_done(cfg_done),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_poll(rx_poll), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .err(err), .err_clr(err_clr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    int acc = 0;
    int wait_states = 0;
    logic hang = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc <= acc + 1;
        else acc <= 0;
    end
    assign PREADY = !hang && (acc >= wait_states);

    int checks = 0;
    int failures = 0;

    logic [20:0] exp_q[$];
    logic [7:0]  rx_q[$];
    int          done_cyc[$];
    logic [20:0] held[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [20:0] wr(input logic [11:0] a,
                                       input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    logic        prev_psel = 1'b0;
    logic        prev_pen = 1'b0;
    logic        prev_rxv = 1'b0;
    logic [20:0] prev_bus = '0;

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL && PENABLE) begin
                if (!prev_pen) chk("setup_first", prev_psel, 1);
                chk("bus_stable", {PWRITE, PADDR, PWDATA}, prev_bus);
                if (PREADY) begin
                    done_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL xfer got=%h exp=none",
                                 {PWRITE, PADDR, PWDATA});
                    end else begin
                        chk("xfer", {PWRITE, PADDR, PWDATA},
                            exp_q.pop_front());
                    end
                end
            end
            if (rx_valid) begin
                chk("rx_pulse", prev_rxv, 0);
                if (rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx got=%h exp=none", rx_data);
                end else begin
                    chk("rx_data", rx_data, rx_q.pop_front());
                end
            end
        end
        prev_psel = PSEL;
        prev_pen  = PENABLE;
        prev_rxv  = rx_valid;
        prev_bus  = {PWRITE, PADDR, PWDATA};
    end

    task automatic push_byte(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge PCLK);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int i = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0 || busy) &&
               i < bound) begin
            @(negedge PCLK);
            i++;
        end
        chk("drain_sb", exp_q.size(), 0);
        chk("drain_rx", rx_q.size(), 0);
    endtask

    task automatic wait_access(input int bound);
        int i = 0;
        while (!(PSEL && PENABLE) && i < bound) begin
            @(negedge PCLK);
            i++;
        end
        chk("reach_access", PSEL && PENABLE, 1);
    endtask

    task automatic hang_run(input bit clr_at_abort, output int n);
        n = 0;
        wait_access(40);
        while (PSEL && PENABLE && n < TO + 10) begin
            n++;
            err_clr = clr_at_abort && (n == TO);
            @(negedge PCLK);
        end
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
    } push_t;

    push_t tbl[9];

    initial begin
        int k;
        int n;
        tbl[0] = '{8'hD8, 1'b1};
        tbl[1] = '{8'h48, 1'b1};
        tbl[2] = '{8'h45, 1'b1};
        tbl[3] = '{8'h4C, 1'b1};
        tbl[4] = '{8'h4C, 1'b1};
        tbl[5] = '{8'h4F, 1'b1};
        tbl[6] = '{8'h01, 1'b1};
        tbl[7] = '{8'h02, 1'b1};
        tbl[8] = '{8'h03, 1'b0};

        PRESET = 1'b1;
        cfg_start = 1'b0;
        cfg_baud = 8'h00;
        cfg_ctrl = 8'h00;
        cfg_state = 8'h00;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        rx_poll = 1'b0;
        err_clr = 1'b0;
        PRDATA = 32'h0;
        repeat (3) @(negedge PCLK);

        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("idle_tx_ready", tx_ready, 1);

        // Fill the queue before config: nothing may be granted yet.
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tx_ready[%0d]", i), tx_ready, tbl[i].exp_ready);
            if (tbl[i].exp_ready) held.push_back(wr(12'h400, tbl[i].data));
            push_byte(tbl[i].data);
        end
        chk("full_ready", tx_ready, 0);
        chk("full_busy", busy, 1);
        chk("pre_cfg_psel", PSEL, 0);

        exp_q.push_back(wr(12'h410, 8'h12));
        exp_q.push_back(wr(12'h408, 8'h03));
        exp_q.push_back(wr(12'h404, 8'h00));
        while (held.size() != 0) exp_q.push_back(held.pop_front());
        done_cyc.delete();
        k = cyc;
        cfg_start = 1'b1;
        cfg_baud = 8'h12;
        cfg_ctrl = 8'h03;
        cfg_state = 8'h00;
        @(negedge PCLK);
        cfg_start = 1'b0;
        for (int i = 0; i < 40 && !cfg_done; i++) @(negedge PCLK);
        chk("cfg_done_lat", cyc - k, 10);
        drain(200);
        chk("xfer_count", done_cyc.size(), 11);
        for (int i = 1; i < done_cyc.size(); i++)
            chk($sformatf("gap%0d", i), done_cyc[i] - done_cyc[i-1], 3);

        // Lone read leaves RX as last-granted.
        PRDATA = 32'h0000005A;
        exp_q.push_back(RD);
        rx_q.push_back(8'h5A);
        rx_poll = 1'b1;
        @(negedge PCLK);
        rx_poll = 1'b0;
        drain(50);

        wait_states = 2;
        PRDATA = 32'h000000A5;
        exp_q.push_back(wr(12'h400, 8'hC1));
        exp_q.push_back(RD);
        exp_q.push_back(wr(12'h400, 8'hC2));
        exp_q.push_back(wr(12'h400, 8'hC3));
        rx_q.push_back(8'hA5);
        rx_poll = 1'b1;
        push_byte(8'hC1);
        rx_poll = 1'b0;
        push_byte(8'hC2);
        push_byte(8'hC3);
        drain(100);
        chk("rx_data_hold", rx_data, 8'hA5);

        // Hung TX write: dropped, following byte still goes out.
        wait_states = 0;
        hang = 1'b1;
        exp_q.push_back(wr(12'h400, 8'h88));
        push_byte(8'h77);
        push_byte(8'h88);
        hang_run(1'b0, n);
        hang = 1'b0;
        chk("to_len_tx", n, TO);
        chk("to_psel", PSEL, 0);
        chk("to_err", err, 1);
        drain(50);
        chk("err_sticky", err, 1);

        // Hung read with err_clr on the abort cycle.
        hang = 1'b1;
        rx_poll = 1'b1;
        @(negedge PCLK);
        rx_poll = 1'b0;
        hang_run(1'b1, n);
        hang = 1'b0;
        chk("to_len_rx", n, TO);
        chk("err_set_wins", err, 1);
        drain(20);
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        chk("err_cleared", err, 0);

        // Config request arriving mid-transfer runs right after it.
        wait_states = 2;
        exp_q.push_back(wr(12'h400, 8'h11));
        exp_q.push_back(wr(12'h410, 8'h34));
        exp_q.push_back(wr(12'h408, 8'h56));
        exp_q.push_back(wr(12'h404, 8'h78));
        exp_q.push_back(wr(12'h400, 8'h22));
        exp_q.push_back(wr(12'h400, 8'h33));
        push_byte(8'h11);
        wait_access(20);
        cfg_start = 1'b1;
        cfg_baud = 8'h34;
        cfg_ctrl = 8'h56;
        cfg_state = 8'h78;
        tx_valid = 1'b1;
        tx_data = 8'h22;
        @(negedge PCLK);
        cfg_start = 1'b0;
        tx_data = 8'h33;
        @(negedge PCLK);
        tx_valid = 1'b0;
        for (int i = 0; i < 30 && !(PSEL && PADDR == 12'h410); i++)
            @(negedge PCLK);
        chk("cfg_seq_start", PADDR, 12'h410);
        chk("cfg_done_clr", cfg_done, 0);
        drain(100);
        chk("cfg_done_again", cfg_done, 1);

        // Reset in the middle of an ACCESS.
        wait_states = 0;
        hang = 1'b1;
        push_byte(8'h99);
        push_byte(8'hAA);
        wait_access(20);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_pwrite", PWRITE, 0);
        chk("mid_rst_paddr", PADDR, 0);
        chk("mid_rst_pwdata", PWDATA, 0);
        chk("mid_rst_cfg_done", cfg_done, 0);
        PRESET = 1'b0;
        hang = 1'b0;
        @(negedge PCLK);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        repeat (10) @(negedge PCLK);
        chk("sb_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
